// File: rtl/ddr4_cmd_sequencer.sv
// DDR4 host command sequencer: turns read/write requests into PRE/ACT/RD/WR.
// Optional closed-page policy with RDA/WRA when DDR4_AUTO_PRECHARGE_EN is defined.
module ddr4_cmd_sequencer #(
    parameter int BGWIDTH   = 2,
    parameter int BAWIDTH   = 2,
    parameter int ADDRWIDTH = 17,
    parameter int COLWIDTH  = 10,
    parameter int TRP       = 4,
    parameter int TRCD      = 4,
    parameter int TCL       = 5,
    parameter int TCWL      = 4,
    parameter int BL        = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_wr,
    input  logic [BGWIDTH-1:0]   req_bg,
    input  logic [BAWIDTH-1:0]   req_ba,
    input  logic [ADDRWIDTH-1:0] req_row,
    input  logic [COLWIDTH-1:0]  req_col,
    input  logic                 stall,
    output logic                 cke,
    output logic                 cs_n,
    output logic                 act_n,
    output logic [ADDRWIDTH-1:0] A,
    output logic [BGWIDTH-1:0]   bg,
    output logic [BAWIDTH-1:0]   ba,
    output logic                 done,
    output logic                 done_wr,
    output logic                 busy
);

`ifdef DDR4_AUTO_PRECHARGE_EN
    localparam bit AP = 1'b1;
`else
    localparam bit AP = 1'b0;
`endif

    localparam int IW    = BGWIDTH + BAWIDTH;
    localparam int NBANK = 2 ** IW;

    localparam logic [7:0] RP_LD  = 8'(TRP - 1);
    localparam logic [7:0] RCD_LD = 8'(TRCD - 1);
    localparam logic [7:0] RD_LD  = 8'(TCL + BL / 2 - 1 + (AP ? TRP : 0));
    localparam logic [7:0] WR_LD  = 8'(TCWL + BL / 2 - 1 + (AP ? TRP : 0));

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_WAIT_RP,
        S_ACT,
        S_WAIT_RCD,
        S_CAS,
        S_WAIT_DATA,
        S_DONE
    } state_t;

    state_t                state;
    state_t                cmd;
    logic [7:0]            cnt;
    logic [NBANK-1:0]      open_vld;
    logic [ADDRWIDTH-1:0]  open_row [NBANK];
    logic                  wr_q;
    logic [BGWIDTH-1:0]    bg_q;
    logic [BAWIDTH-1:0]    ba_q;
    logic [ADDRWIDTH-1:0]  row_q;
    logic [COLWIDTH-1:0]   col_q;
    logic [IW-1:0]         idx;
    logic [IW-1:0]         req_idx;
    logic [ADDRWIDTH-1:0]  a_pre;
    logic [ADDRWIDTH-1:0]  a_cas;

    assign idx     = {bg_q, ba_q};
    assign req_idx = {req_bg, req_ba};

    // A-bus images of the PRE and RD/WR commands for the latched request
    always_comb begin
        a_pre            = '0;
        a_pre[15]        = 1'b1;
        a_cas            = '0;
        a_cas[16]        = 1'b1;
        a_cas[14]        = ~wr_q;
        a_cas[10]        = AP;
        a_cas[COLWIDTH-1:0] = col_q;
    end

    // An expiring wait folds straight into the next command so it issues without a bubble
    always_comb begin
        cmd = state;
        if (state == S_WAIT_RP && cnt == 8'd0)
            cmd = S_ACT;
        else if (state == S_WAIT_RCD && cnt == 8'd0)
            cmd = S_CAS;
    end

    // Sequencer FSM with registered command pins, counters and open-row table
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cnt       <= 8'd0;
            open_vld  <= '0;
            wr_q      <= 1'b0;
            bg_q      <= '0;
            ba_q      <= '0;
            row_q     <= '0;
            col_q     <= '0;
            cke       <= 1'b0;
            cs_n      <= 1'b1;
            act_n     <= 1'b1;
            A         <= '0;
            bg        <= '0;
            ba        <= '0;
            req_ready <= 1'b0;
            done      <= 1'b0;
            done_wr   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            cke     <= 1'b1;
            cs_n    <= 1'b1;
            act_n   <= 1'b1;
            A       <= '0;
            done    <= 1'b0;
            done_wr <= 1'b0;
            unique case (cmd)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        wr_q      <= req_wr;
                        bg_q      <= req_bg;
                        ba_q      <= req_ba;
                        row_q     <= req_row;
                        col_q     <= req_col;
                        if (open_vld[req_idx] && open_row[req_idx] == req_row)
                            state <= S_CAS;
                        else if (open_vld[req_idx])
                            state <= S_PRE;
                        else
                            state <= S_ACT;
                    end
                end
                S_PRE: begin
                    state <= S_PRE;
                    if (!stall) begin
                        cs_n          <= 1'b0;
                        A             <= a_pre;
                        bg            <= bg_q;
                        ba            <= ba_q;
                        open_vld[idx] <= 1'b0;
                        cnt           <= RP_LD;
                        state         <= S_WAIT_RP;
                    end
                end
                S_ACT: begin
                    state <= S_ACT;
                    if (!stall) begin
                        cs_n          <= 1'b0;
                        act_n         <= 1'b0;
                        A             <= row_q;
                        bg            <= bg_q;
                        ba            <= ba_q;
                        open_vld[idx] <= 1'b1;
                        open_row[idx] <= row_q;
                        cnt           <= RCD_LD;
                        state         <= S_WAIT_RCD;
                    end
                end
                S_CAS: begin
                    state <= S_CAS;
                    if (!stall) begin
                        cs_n  <= 1'b0;
                        A     <= a_cas;
                        bg    <= bg_q;
                        ba    <= ba_q;
                        cnt   <= wr_q ? WR_LD : RD_LD;
                        state <= S_WAIT_DATA;
                        if (AP)
                            open_vld[idx] <= 1'b0;
                    end
                end
                S_WAIT_RP, S_WAIT_RCD: begin
                    cnt <= cnt - 8'd1;
                end
                S_WAIT_DATA: begin
                    if (cnt == 8'd0) begin
                        state   <= S_DONE;
                        done    <= 1'b1;
                        done_wr <= wr_q;
                        busy    <= 1'b0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_DONE: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr4_cmd_sequencer.sv
// Directed bench for ddr4_cmd_sequencer: reset, closed/hit/conflict, stall, abort.
// Expected timings follow the active page policy (DDR4_AUTO_PRECHARGE_EN).
module tb_ddr4_cmd_sequencer;

`ifdef DDR4_AUTO_PRECHARGE_EN
    localparam int AP = 1;
`else
    localparam int AP = 0;
`endif
    localparam logic [31:0] A10 = (AP != 0) ? 32'h400 : 32'h0;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wr = 1'b0;
    logic [1:0]  req_bg = '0;
    logic [1:0]  req_ba = '0;
    logic [16:0] req_row = '0;
    logic [9:0]  req_col = '0;
    logic        stall = 1'b0;
    logic        cke;
    logic        cs_n;
    logic        act_n;
    logic [16:0] A;
    logic [1:0]  bg;
    logic [1:0]  ba;
    logic        done;
    logic        done_wr;
    logic        busy;

    int checks = 0;
    int errors = 0;

    int          ncmd;
    int          cmd_cyc [4];
    logic [16:0] cmd_a [4];
    logic        cmd_act [4];
    logic [3:0]  cmd_bgba [4];
    int          done_cyc;
    logic        done_w;

    ddr4_cmd_sequencer dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row), .req_col(req_col),
        .stall(stall), .cke(cke), .cs_n(cs_n), .act_n(act_n), .A(A),
        .bg(bg), .ba(ba), .done(done), .done_wr(done_wr), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        chk("ready_before_req", {31'd0, req_ready}, 32'd1);
    endtask

    // Issue one request and log commands/done by cycle index after accept
    task automatic do_req(input logic w, input logic [1:0] g, input logic [1:0] b,
                          input logic [16:0] r, input logic [9:0] c, input int stall_n);
        ncmd = 0;
        done_cyc = -1;
        done_w = 1'b0;
        wait_ready();
        req_valid = 1'b1;
        req_wr = w;
        req_bg = g;
        req_ba = b;
        req_row = r;
        req_col = c;
        tick();
        req_valid = 1'b0;
        if (stall_n > 0) stall = 1'b1;
        for (int cyc = 1; cyc <= 60 && done_cyc < 0; cyc++) begin
            tick();
            if (cs_n == 1'b0 && ncmd < 4) begin
                cmd_cyc[ncmd]  = cyc;
                cmd_a[ncmd]    = A;
                cmd_act[ncmd]  = ~act_n;
                cmd_bgba[ncmd] = {bg, ba};
                ncmd++;
            end
            if (done === 1'b1) begin
                done_cyc = cyc;
                done_w = done_wr;
            end
            if (cyc == stall_n) stall = 1'b0;
        end
        stall = 1'b0;
    endtask

    initial begin
        int seen;

        // reset held for three cycles
        reset_n = 1'b0;
        tick(); tick(); tick();
        chk("rst_cke", {31'd0, cke}, 32'd0);
        chk("rst_cs_n", {31'd0, cs_n}, 32'd1);
        chk("rst_act_n", {31'd0, act_n}, 32'd1);
        chk("rst_A", {15'd0, A}, 32'd0);
        chk("rst_bgba", {28'd0, bg, ba}, 32'd0);
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_done_busy", {29'd0, done, done_wr, busy}, 32'd0);
        reset_n = 1'b1;
        tick();
        chk("rel_cke", {31'd0, cke}, 32'd1);
        chk("rel_ready", {31'd0, req_ready}, 32'd1);
        chk("rel_cs_n", {31'd0, cs_n}, 32'd1);

        // closed-bank read
        do_req(1'b0, 2'd1, 2'd2, 17'h1ABC, 10'h03F, 0);
        chk("cr_ncmd", 32'(ncmd), 32'd2);
        chk("cr_act_cyc", 32'(cmd_cyc[0]), 32'd1);
        chk("cr_act_n", {31'd0, cmd_act[0]}, 32'd1);
        chk("cr_act_A", {15'd0, cmd_a[0]}, 32'h1ABC);
        chk("cr_act_bgba", {28'd0, cmd_bgba[0]}, 32'h6);
        chk("cr_rd_cyc", 32'(cmd_cyc[1]), 32'd5);
        chk("cr_rd_A", {15'd0, cmd_a[1]}, 32'h1403F | A10);
        chk("cr_done_cyc", 32'(done_cyc), 32'(14 + 4 * AP));
        chk("cr_done_wr", {31'd0, done_w}, 32'd0);
        chk("cr_busy_done", {31'd0, busy}, 32'd0);
        tick();
        chk("cr_ready_after", {31'd0, req_ready}, 32'd1);

        // write to the same bank and row (hit under open-page)
        do_req(1'b1, 2'd1, 2'd2, 17'h1ABC, 10'h055, 0);
        chk("hit_ncmd", 32'(ncmd), 32'(1 + AP));
        chk("hit_wr_cyc", 32'(cmd_cyc[ncmd-1]), 32'(1 + 4 * AP));
        chk("hit_wr_A", {15'd0, cmd_a[ncmd-1]}, 32'h10055 | A10);
        chk("hit_done_cyc", 32'(done_cyc), 32'(9 + 8 * AP));
        chk("hit_done_wr", {31'd0, done_w}, 32'd1);

        // read of a different row in that bank (conflict under open-page)
        do_req(1'b0, 2'd1, 2'd2, 17'h0001, 10'h000, 0);
        chk("cf_ncmd", 32'(ncmd), 32'(3 - AP));
        chk("cf_first_act", {31'd0, cmd_act[0]}, 32'(AP));
        chk("cf_first_A", {15'd0, cmd_a[0]}, (AP != 0) ? 32'h1 : 32'h8000);
        chk("cf_first_cyc", 32'(cmd_cyc[0]), 32'd1);
        chk("cf_act_cyc", 32'(cmd_cyc[1-AP]), 32'(5 - 4 * AP));
        chk("cf_rd_cyc", 32'(cmd_cyc[ncmd-1]), 32'(9 - 4 * AP));
        chk("cf_rd_A", {15'd0, cmd_a[ncmd-1]}, 32'h14000 | A10);
        chk("cf_done_cyc", 32'(done_cyc), 32'd18);

        // stall held six cycles over a pending ACT
        do_req(1'b0, 2'd0, 2'd0, 17'h0022, 10'h001, 6);
        chk("st_ncmd", 32'(ncmd), 32'd2);
        chk("st_act_cyc", 32'(cmd_cyc[0]), 32'd7);
        chk("st_act_n", {31'd0, cmd_act[0]}, 32'd1);
        chk("st_rd_cyc", 32'(cmd_cyc[1]), 32'd11);
        chk("st_done_cyc", 32'(done_cyc), 32'(20 + 4 * AP));

        // reset during WAIT_RCD aborts the request
        wait_ready();
        req_valid = 1'b1;
        req_wr = 1'b0;
        req_bg = 2'd3;
        req_ba = 2'd1;
        req_row = 17'h0044;
        req_col = 10'h002;
        tick();
        req_valid = 1'b0;
        tick(); tick();
        reset_n = 1'b0;
        tick(); tick();
        chk("ab_rst_busy", {31'd0, busy}, 32'd0);
        chk("ab_rst_cs_n", {31'd0, cs_n}, 32'd1);
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cs_n !== 1'b1 || done !== 1'b0) seen++;
        end
        chk("ab_no_cmd_done", 32'(seen), 32'd0);
        do_req(1'b0, 2'd3, 2'd1, 17'h0044, 10'h002, 0);
        chk("ab_re_ncmd", 32'(ncmd), 32'd2);
        chk("ab_re_act", {31'd0, cmd_act[0]}, 32'd1);
        chk("ab_re_act_cyc", 32'(cmd_cyc[0]), 32'd1);
        chk("ab_re_done", 32'(done_cyc), 32'(14 + 4 * AP));

        // same bank reopened after reset: earlier row must not count as a hit
        do_req(1'b0, 2'd1, 2'd2, 17'h0001, 10'h000, 0);
        chk("ab_tbl_act", {31'd0, cmd_act[0]}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
